// File: rtl/fir_dec_pkg.sv
// Shared definitions for the polyphase symmetric-FIR decimator.
// Holds the derived-size helpers, the default-configuration constants,
// the controller state encoding and the accumulator round/saturate helper.
package fir_dec_pkg;

    // Default configuration
    localparam int ORD_DEF         = 255;
    localparam int M_DEF           = 8;
    localparam int COEFF_SIZE_DEF  = 16;
    localparam int SAMPLE_SIZE_DEF = 16;

    // Number of taps
    function automatic int f_ntaps(input int ord);
        return ord + 1;
    endfunction

    // Number of symmetric coefficient pairs
    function automatic int f_npair(input int ord);
        return (ord + 1) / 2;
    endfunction

    // Sample buffer depth: one window plus room for a full decimation
    // period of new writes while a window is being read.
    function automatic int f_depth(input int ord, input int m);
        return ord + 1 + m;
    endfunction

    // Accumulator width: pre-add growth, full product, plus log2 of the
    // number of accumulated pair products.
    function automatic int f_acc_w(input int ord, input int sample_size, input int coeff_size);
        return sample_size + coeff_size + 1 + $clog2((ord + 1) / 2);
    endfunction

    // Sample buffer pointer width
    function automatic int f_ptr_w(input int ord, input int m);
        return $clog2(ord + 1 + m);
    endfunction

    localparam int NTAPS = f_ntaps(ORD_DEF);
    localparam int NPAIR = f_npair(ORD_DEF);
    localparam int DEPTH = f_depth(ORD_DEF, M_DEF);
    localparam int ACC_W = f_acc_w(ORD_DEF, SAMPLE_SIZE_DEF, COEFF_SIZE_DEF);
    localparam int PTR_W = f_ptr_w(ORD_DEF, M_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } dec_state_t;

    // Convert a Q(S+C-2) accumulator to a Q(S-1) sample: round half up by
    // adding half an output LSB before the arithmetic shift, then clamp to
    // the signed sample range. The caller keeps the low sample_size bits.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 coeff_size,
        input int                 sample_size
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (acc + (64'sd1 <<< (coeff_size - 2))) >>> (coeff_size - 1);
        max_v = (64'sd1 <<< (sample_size - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (sample_size - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_mac.sv
// Pre-add / multiply / accumulate datapath of the decimator.
// Ports:
//   clk, nrst  clock and asynchronous active-low reset
//   clear      zero the accumulator and drop any in-flight products
//   in_valid   xa/xb/coef carry a pair to accumulate this cycle
//   xa, xb     the two symmetric samples of one coefficient pair
//   coef       shared coefficient of the pair
//   acc        running accumulator
module dec_mac #(
    parameter int SAMPLE_SIZE = 16,
    parameter int COEFF_SIZE  = 16,
    parameter int ACC_W       = 40
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_SIZE-1:0]  xa,
    input  logic signed [SAMPLE_SIZE-1:0]  xb,
    input  logic signed [COEFF_SIZE-1:0]   coef,
    output logic signed [ACC_W-1:0]        acc
);

    localparam int P = SAMPLE_SIZE + COEFF_SIZE + 1;

    logic signed [SAMPLE_SIZE:0]   pre_r;
    logic signed [COEFF_SIZE-1:0]  h_d_r;
    logic                          pre_v_r;
    logic signed [P-1:0]           prod_r;
    logic                          prod_v_r;
    logic signed [ACC_W-1:0]       acc_r;
    logic signed [P-1:0]           pre_ext_s;
    logic signed [P-1:0]           h_ext_s;

    // Sign-extend both multiplier operands to the full product width
    always_comb begin
        pre_ext_s = {{COEFF_SIZE{pre_r[SAMPLE_SIZE]}}, pre_r};
        h_ext_s   = {{(SAMPLE_SIZE + 1){h_d_r[COEFF_SIZE-1]}}, h_d_r};
    end

    // Three-stage pre-add, product and accumulate pipeline
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pre_r    <= '0;
            h_d_r    <= '0;
            pre_v_r  <= 1'b0;
            prod_r   <= '0;
            prod_v_r <= 1'b0;
            acc_r    <= '0;
        end else if (clear) begin
            pre_v_r  <= 1'b0;
            prod_v_r <= 1'b0;
            acc_r    <= '0;
        end else begin
            pre_r    <= {xa[SAMPLE_SIZE-1], xa} + {xb[SAMPLE_SIZE-1], xb};
            h_d_r    <= coef;
            pre_v_r  <= in_valid;
            prod_r   <= pre_ext_s * h_ext_s;
            prod_v_r <= pre_v_r;
            if (prod_v_r) begin
                acc_r <= acc_r + {{(ACC_W - P){prod_r[P-1]}}, prod_r};
            end
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/fir_decimator.sv
// Polyphase symmetric-FIR decimator: accepts samples on din_valid and emits
// one filtered, rounded and saturated output per M accepted samples.
// Ports:
//   clk, nrst   clock and asynchronous active-low reset
//   din         input sample, accepted when din_valid=1 and c_we=0
//   din_valid   one-cycle input strobe
//   dout        decimated output, holds its last value
//   dout_valid  one-cycle pulse when dout updates
//   overrun     one-cycle pulse when a decimation trigger is dropped
//   c_we        coefficient load mode; aborts any computation
//   c_in        coefficient data
//   c_addr      coefficient pair index k (h[k] = h[N-1-k])
module fir_decimator
    import fir_dec_pkg::*;
#(
    parameter int ORD         = 255,
    parameter int M           = 8,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic signed [SAMPLE_SIZE-1:0]      din,
    input  logic                               din_valid,
    output logic signed [SAMPLE_SIZE-1:0]      dout,
    output logic                               dout_valid,
    output logic                               overrun,
    input  logic                               c_we,
    input  logic signed [COEFF_SIZE-1:0]       c_in,
    input  logic [$clog2((ORD+1)/2)-1:0]       c_addr
);

    localparam int N      = f_ntaps(ORD);
    localparam int NP     = f_npair(ORD);
    localparam int DEP    = f_depth(ORD, M);
    localparam int AW     = f_acc_w(ORD, SAMPLE_SIZE, COEFF_SIZE);
    localparam int PW     = f_ptr_w(ORD, M);
    localparam int KW     = $clog2(NP);
    localparam int PHW    = $clog2(M);
    localparam int FW     = $clog2(N + 1);
    localparam logic [PW:0] DEPTH_X = (PW + 1)'(DEP);
    // Distance from newest back to the oldest window sample, folded to a
    // positive offset: newest - (N-1) == newest + (DEPTH - (N-1)) mod DEPTH.
    localparam logic [PW:0] OFFS_B  = (PW + 1)'(DEP - (N - 1));

    dec_state_t                      state_r;
    logic [PW-1:0]                   wptr_r;
    logic [PW-1:0]                   newest_r;
    logic [PHW-1:0]                  phase_r;
    logic [FW-1:0]                   fill_r;
    logic [KW-1:0]                   kcnt_r;
    logic [1:0]                      dcnt_r;
    logic                            rd_v_r;
    logic signed [SAMPLE_SIZE-1:0]   xa_r;
    logic signed [SAMPLE_SIZE-1:0]   xb_r;
    logic signed [COEFF_SIZE-1:0]    h_r;
    logic signed [SAMPLE_SIZE-1:0]   sram [DEP];
    logic signed [COEFF_SIZE-1:0]    cram [NP];
    logic signed [AW-1:0]            acc_s;

    logic                            accept_s;
    logic                            trig_s;
    logic                            start_s;
    logic [PW:0]                     sum_a_s;
    logic [PW:0]                     sum_b_s;
    logic [PW:0]                     addr_a_s;
    logic [PW:0]                     addr_b_s;

    // Input acceptance, decimation trigger and computation start
    always_comb begin
        accept_s = din_valid & ~c_we;
        trig_s   = accept_s & (phase_r == PHW'(M - 1));
        start_s  = trig_s & (fill_r >= FW'(N - 1)) & (state_r == IDLE);
    end

    // Circular read addresses of the current pair: newest-k and newest-(N-1)+k
    always_comb begin
        sum_a_s = {1'b0, newest_r} + DEPTH_X - (PW + 1)'(kcnt_r);
        sum_b_s = {1'b0, newest_r} + OFFS_B + (PW + 1)'(kcnt_r);
        if (sum_a_s >= DEPTH_X) begin
            addr_a_s = sum_a_s - DEPTH_X;
        end else begin
            addr_a_s = sum_a_s;
        end
        if (sum_b_s >= DEPTH_X) begin
            addr_b_s = sum_b_s - DEPTH_X;
        end else begin
            addr_b_s = sum_b_s;
        end
    end

    // Write pointer, decimation phase and saturating fill level
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_r  <= '0;
            phase_r <= '0;
            fill_r  <= '0;
        end else if (c_we) begin
            phase_r <= '0;
            fill_r  <= '0;
        end else if (accept_s) begin
            wptr_r  <= (wptr_r == PW'(DEP - 1)) ? '0 : wptr_r + PW'(1);
            phase_r <= (phase_r == PHW'(M - 1)) ? '0 : phase_r + PHW'(1);
            fill_r  <= (fill_r == FW'(N)) ? fill_r : fill_r + FW'(1);
        end
    end

    // Sample buffer: one write port, two registered read ports
    always_ff @(posedge clk) begin
        if (accept_s) begin
            sram[wptr_r] <= din;
        end
        xa_r <= sram[addr_a_s[PW-1:0]];
        xb_r <= sram[addr_b_s[PW-1:0]];
    end

    // Coefficient memory: written in load mode, otherwise read at pair k
    always_ff @(posedge clk) begin
        if (c_we) begin
            cram[c_addr] <= c_in;
        end
        h_r <= cram[kcnt_r];
    end

    // Marks the read-stage registers as holding a live pair
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_v_r <= 1'b0;
        end else begin
            rd_v_r <= (state_r == RUN) & ~c_we;
        end
    end

    dec_mac #(
        .SAMPLE_SIZE (SAMPLE_SIZE),
        .COEFF_SIZE  (COEFF_SIZE),
        .ACC_W       (AW)
    ) u_mac (
        .clk      (clk),
        .nrst     (nrst),
        .clear    (start_s | c_we),
        .in_valid (rd_v_r),
        .xa       (xa_r),
        .xb       (xb_r),
        .coef     (h_r),
        .acc      (acc_s)
    );

    // Controller: sequences pair reads, waits for the pipeline to drain,
    // then registers the converted output. Load mode aborts at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            newest_r   <= '0;
            kcnt_r     <= '0;
            dcnt_r     <= 2'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (c_we) begin
            state_r    <= IDLE;
            kcnt_r     <= '0;
            dcnt_r     <= 2'd0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overrun    <= trig_s & (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r  <= RUN;
                        newest_r <= wptr_r;
                        kcnt_r   <= '0;
                    end
                end
                RUN: begin
                    if (kcnt_r == KW'(NP - 1)) begin
                        state_r <= DRAIN;
                        dcnt_r  <= 2'd0;
                    end else begin
                        kcnt_r <= kcnt_r + KW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt_r == 2'd2) begin
                        state_r <= OUT;
                    end else begin
                        dcnt_r <= dcnt_r + 2'd1;
                    end
                end
                OUT: begin
                    dout       <= SAMPLE_SIZE'(round_sat({{(64 - AW){acc_s[AW-1]}}, acc_s},
                                                         COEFF_SIZE, SAMPLE_SIZE));
                    dout_valid <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;

    localparam int ORD = 15;
    localparam int M   = 4;
    localparam int N   = 16;
    localparam int NP  = 8;
    localparam int CS  = 16;
    localparam int SS  = 16;
    localparam int LAT = NP + 4;

    logic               clk = 1'b0;
    logic               nrst;
    logic signed [15:0] din;
    logic               din_valid;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               overrun;
    logic               c_we;
    logic signed [15:0] c_in;
    logic [2:0]         c_addr;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [15:0]        xs[$];
    logic signed [15:0] h_m [NP];
    int                 phase_m = 0;
    int                 fill_m  = 0;
    int                 cyc     = 0;
    int                 start_m = -1000;
    int                 exp_t   = -1;
    logic [15:0]        exp_val = 16'h0000;
    logic [15:0]        dout_m  = 16'h0000;
    int                 dv_cnt  = 0;
    int                 ovr_cnt = 0;
    logic [15:0]        out_q[$];

    always #5 clk = ~clk;

    fir_decimator #(
        .ORD         (ORD),
        .M           (M),
        .COEFF_SIZE  (CS),
        .SAMPLE_SIZE (SS)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun),
        .c_we       (c_we),
        .c_in       (c_in),
        .c_addr     (c_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Direct-form FIR over the newest N accepted samples, round half up, clamp
    function automatic logic [15:0] ref_out();
        longint acc;
        longint r;
        int     sz;
        acc = 0;
        sz  = xs.size();
        for (int n = 0; n < N; n++) begin
            int k;
            k = (n < NP) ? n : (N - 1 - n);
            acc += longint'($signed(xs[sz - 1 - n])) * longint'(h_m[k]);
        end
        r = acc + (longint'(1) << (CS - 2));
        r = r >>> (CS - 1);
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    // One clock edge: advance the model with the inputs held over the edge,
    // then compare all outputs.
    task automatic tick();
        logic exp_dv;
        logic exp_ovr;
        logic trig;
        @(posedge clk);
        #1;
        cyc++;
        exp_dv  = 1'b0;
        exp_ovr = 1'b0;
        if (c_we) begin
            h_m[c_addr] = c_in;
            phase_m = 0;
            fill_m  = 0;
            exp_t   = -1;
            start_m = -1000;
        end else if (din_valid) begin
            xs.push_back(din);
            fill_m  = (fill_m + 1 > N) ? N : fill_m + 1;
            trig    = (phase_m == M - 1);
            phase_m = (phase_m + 1) % M;
            if (trig) begin
                if (cyc >= start_m + 1 && cyc <= start_m + LAT) begin
                    exp_ovr = 1'b1;
                end else if (fill_m >= N) begin
                    start_m = cyc;
                    exp_t   = cyc + LAT;
                    exp_val = ref_out();
                end
            end
        end
        if (!c_we && cyc == exp_t) begin
            exp_dv = 1'b1;
            dout_m = exp_val;
        end
        if (dout_valid) begin
            dv_cnt++;
            out_q.push_back(dout);
        end
        if (overrun) ovr_cnt++;
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, exp_dv});
        chk("dout", {16'd0, dout}, {16'd0, dout_m});
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        din_valid = 1'b1;
        din       = d;
        tick();
        din_valid = 1'b0;
        for (int i = 1; i < gap; i++) tick();
    endtask

    task automatic cwr(input logic [2:0] a, input logic [15:0] v);
        c_we   = 1'b1;
        c_addr = a;
        c_in   = v;
        tick();
        c_we   = 1'b0;
    endtask

    initial begin
        int dv0;
        logic [15:0] imp_exp [6];
        imp_exp[0] = 16'h0000; imp_exp[1] = 16'h0200; imp_exp[2] = 16'h0400;
        imp_exp[3] = 16'h0280; imp_exp[4] = 16'h0080; imp_exp[5] = 16'h0000;

        nrst = 1'b0; din = 16'sd0; din_valid = 1'b0;
        c_we = 1'b0; c_in = 16'sd0; c_addr = 3'd0;
        #12;
        chk("reset_dout", {16'd0, dout}, 32'd0);
        chk("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        nrst = 1'b1;

        // DC gain
        for (int k = 0; k < NP; k++) cwr(3'(k), 16'h0800);
        dv_cnt = 0;
        for (int i = 0; i < 24; i++) send(16'h1000, 4);
        repeat (LAT) tick();
        chk("dc_pulses", dv_cnt, 32'd3);
        chk("dc_value", {16'd0, dout}, 32'h0000_1000);

        // Impulse response through the symmetric coefficient set
        for (int k = 0; k < NP; k++) cwr(3'(k), 16'((k + 1) * 16'h0100));
        out_q.delete();
        for (int i = 0; i < 16; i++) send(16'h0000, 4);
        send(16'h4000, 4);
        for (int i = 0; i < 19; i++) send(16'h0000, 4);
        repeat (LAT) tick();
        chk("imp_count", out_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("imp_value", {16'd0, out_q[i]}, {16'd0, imp_exp[i]});

        // Saturation both ways
        for (int k = 0; k < NP; k++) cwr(3'(k), 16'h4000);
        for (int i = 0; i < 20; i++) send(16'h7FFF, 4);
        repeat (LAT) tick();
        chk("sat_pos", {16'd0, dout}, 32'h0000_7FFF);
        for (int i = 0; i < 20; i++) send(16'h8000, 4);
        repeat (LAT) tick();
        chk("sat_neg", {16'd0, dout}, 32'h0000_8000);

        // Random coefficients and data at the loss-free rate
        for (int k = 0; k < NP; k++) cwr(3'(k), 16'($urandom_range(0, 16'h1FFF)) - 16'h1000);
        dv_cnt = 0; ovr_cnt = 0;
        for (int i = 0; i < 40; i++) send(16'($urandom), 4);
        repeat (LAT) tick();
        chk("rate_pulses", dv_cnt, 32'd7);
        chk("rate_no_overrun", ovr_cnt, 32'd0);

        // Back-to-back input: triggers while busy are dropped
        ovr_cnt = 0;
        for (int i = 0; i < 64; i++) send(16'($urandom), 1);
        repeat (20) tick();
        chk("burst_overrun_seen", {31'd0, ovr_cnt > 0}, 32'd1);

        // Abort by entering load mode during a computation
        cwr(3'd0, h_m[0]);
        for (int i = 0; i < 15; i++) send(16'($urandom), 4);
        send(16'($urandom), 1);
        repeat (5) tick();
        dv0 = dv_cnt;
        cwr(3'd0, h_m[0]);
        repeat (20) tick();
        chk("abort_no_pulse", dv_cnt, dv0);
        for (int i = 0; i < 15; i++) send(16'($urandom), 4);
        chk("abort_refill_silent", dv_cnt, dv0);
        send(16'($urandom), 4);
        repeat (LAT) tick();
        chk("abort_refill_output", dv_cnt, dv0 + 1);

        // Asynchronous reset in the middle of a computation
        for (int i = 0; i < 3; i++) send(16'($urandom), 4);
        send(16'($urandom), 1);
        repeat (3) tick();
        nrst = 1'b0;
        #1;
        chk("midrun_reset_dout", {16'd0, dout}, 32'd0);
        chk("midrun_reset_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("midrun_reset_overrun", {31'd0, overrun}, 32'd0);
        dout_m = 16'h0000; phase_m = 0; fill_m = 0; start_m = -1000; exp_t = -1;
        repeat (2) tick();
        nrst = 1'b1;
        dv0 = dv_cnt;
        for (int i = 0; i < 16; i++) send(16'($urandom), 4);
        repeat (LAT) tick();
        chk("post_reset_output", dv_cnt, dv0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
